// File: rtl/key_counter.sv
// Debounced, auto-repeating up/down/clear counter driven by three raw active-low buttons.
// A key held through reset is ignored until it has been seen released.
module key_counter #(
    parameter int DEBOUNCE     = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int MAX_COUNT    = 999
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_clr,
    output logic [9:0] count,
    output logic       wrap
);

    localparam int DW       = $clog2(DEBOUNCE);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = $clog2(HOLD_MAX);
    localparam logic [9:0] MAX_VAL = 10'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Key index: 0 = up, 1 = down, 2 = clear.
    logic [2:0]    keys_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_q;
    logic [2:0]    armed;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];
    logic [1:0]    boot_sr;

    state_t        state;
    logic          dir_down;
    logic [HW-1:0] hold;

    logic          both_held;
    logic          active_released;
    logic          step_down;
    logic [9:0]    step_count;
    logic          step_wrap;
    logic [HW-1:0] hold_limit;

    assign keys_raw = {key_clr, key_down, key_up};

    // Synchronizers, per-key debounce, and the post-reset arming that keeps
    // a key held across reset from producing a press.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            stable   <= '1;
            stable_q <= '1;
            armed    <= '0;
            boot_sr  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= keys_raw;
            sync2    <= sync1;
            stable_q <= stable;
            boot_sr  <= {boot_sr[0], 1'b1};
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                if (boot_sr[1] && stable[i] && sync2[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        press           = stable_q & ~stable & armed;
        both_held       = ~stable[0] & ~stable[1];
        active_released = dir_down ? stable[1] : stable[0];
        hold_limit      = (state == DELAY) ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_RATE - 1);
        // In IDLE the direction comes from the press itself; otherwise from the latched key.
        step_down       = (state == IDLE) ? ~press[0] : dir_down;
        step_count      = '0;
        step_wrap       = 1'b0;
        if (step_down) begin
            if (count == 10'd0) begin
                step_count = MAX_VAL;
                step_wrap  = 1'b1;
            end else begin
                step_count = count - 10'd1;
            end
        end else begin
            if (count >= MAX_VAL) begin
                step_count = 10'd0;
                step_wrap  = 1'b1;
            end else begin
                step_count = count + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            wrap     <= 1'b0;
            hold     <= '0;
            dir_down <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (press[2]) begin
                count <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!both_held && (press[0] || press[1])) begin
                            count    <= step_count;
                            wrap     <= step_wrap;
                            dir_down <= ~press[0];
                            hold     <= '0;
                            state    <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (active_released || both_held) begin
                            state <= IDLE;
                        end else if (hold == hold_limit) begin
                            count <= step_count;
                            wrap  <= step_wrap;
                            hold  <= '0;
                            state <= REPEAT;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_counter.sv
// Directed bench for key_counter with short debounce/repeat parameters.
module tb_key_counter;

    logic       clk;
    logic       rst_n;
    logic       key_up;
    logic       key_down;
    logic       key_clr;
    logic [9:0] count;
    logic       wrap;

    int vectors;
    int miscompares;

    key_counter #(
        .DEBOUNCE    (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .MAX_COUNT   (999)
    ) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .key_up  (key_up),
        .key_down(key_down),
        .key_clr (key_clr),
        .count   (count),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cw(input string tag, input logic [9:0] exp_count, input logic exp_wrap);
        check({tag, "_count"}, {1'b0, count}, {1'b0, exp_count});
        check({tag, "_wrap"}, {10'd0, wrap}, {10'd0, exp_wrap});
    endtask

    initial begin
        int exp_c;
        int cap;
        vectors     = 0;
        miscompares = 0;

        // Reset with key_up held: no step afterwards until released and re-pressed.
        rst_n    = 1'b0;
        key_up   = 1'b0;
        key_down = 1'b1;
        key_clr  = 1'b1;
        tick(3);
        check_cw("reset", 10'd0, 1'b0);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            check_cw("held_thru_reset", 10'd0, 1'b0);
        end
        key_up = 1'b1;
        tick(15);
        check_cw("after_release", 10'd0, 1'b0);

        // Single press: step lands on cycle 7, release changes nothing.
        key_up = 1'b0;
        tick(6);
        check_cw("single_c6", 10'd0, 1'b0);
        tick(1);
        check_cw("single_c7", 10'd1, 1'b0);
        tick(3);
        key_up = 1'b1;
        tick(12);
        check_cw("single_release", 10'd1, 1'b0);

        // Clear.
        key_clr = 1'b0;
        tick(10);
        check_cw("clear", 10'd0, 1'b0);
        key_clr = 1'b1;
        tick(10);

        // Bouncy down press: exactly one step 0 -> 999 with one wrap pulse.
        for (int i = 0; i < 10; i++) begin
            key_down = i[0];
            tick(2);
        end
        key_down = 1'b0;
        tick(6);
        check_cw("bounce_c26", 10'd0, 1'b0);
        tick(1);
        check_cw("bounce_c27", 10'd999, 1'b1);
        tick(1);
        check_cw("bounce_c28", 10'd999, 1'b0);
        key_down = 1'b1;
        tick(12);
        check_cw("bounce_release", 10'd999, 1'b0);

        // Wrap up: 999 -> 0.
        key_up = 1'b0;
        tick(6);
        check_cw("wrapup_c6", 10'd999, 1'b0);
        tick(1);
        check_cw("wrapup_c7", 10'd0, 1'b1);
        tick(1);
        check_cw("wrapup_c8", 10'd0, 1'b0);
        key_up = 1'b1;
        tick(12);
        check_cw("wrapup_release", 10'd0, 1'b0);

        // Auto-repeat: steps at 7, 27, 32, ... 62, released after cycle 60.
        key_up = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            tick(1);
            cap   = (c > 62) ? 62 : c;
            exp_c = (c >= 7) ? 1 : 0;
            if (c >= 27) exp_c = exp_c + (cap - 27) / 5 + 1;
            check_cw($sformatf("repeat_c%0d", c), 10'(exp_c), 1'b0);
            if (c == 60) key_up = 1'b1;
        end
        tick(10);
        check_cw("repeat_idle", 10'd9, 1'b0);

        // Clear during REPEAT: steps at 7, 27, 32, 37, clear lands on cycle 40.
        key_up = 1'b0;
        tick(33);
        check_cw("clr_rep_c33", 10'd12, 1'b0);
        key_clr = 1'b0;
        tick(6);
        check_cw("clr_rep_c39", 10'd13, 1'b0);
        tick(1);
        check_cw("clr_rep_c40", 10'd0, 1'b0);
        tick(20);
        check_cw("clr_rep_stopped", 10'd0, 1'b0);
        key_up  = 1'b1;
        key_clr = 1'b1;
        tick(12);
        check_cw("clr_rep_release", 10'd0, 1'b0);

        // Up held, then down joins: count freezes.
        key_up = 1'b0;
        tick(7);
        check_cw("both_c7", 10'd1, 1'b0);
        tick(3);
        key_down = 1'b0;
        tick(6);
        check_cw("both_c16", 10'd1, 1'b0);
        tick(34);
        check_cw("both_c50", 10'd1, 1'b0);
        key_up   = 1'b1;
        key_down = 1'b1;
        tick(12);
        check_cw("both_release", 10'd1, 1'b0);

        // Up and down pressed on the same cycle: no step.
        key_up   = 1'b0;
        key_down = 1'b0;
        tick(30);
        check_cw("both_same_cycle", 10'd1, 1'b0);
        key_up   = 1'b1;
        key_down = 1'b1;
        tick(12);
        check_cw("both_same_release", 10'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
